mac_array_sequencer: RTL

MAC_ARRAY_SEQUENCER -- requirements
Module: mac_array_sequencer

---
 rtl/mac_array_sequencer_pkg.sv | 33 +++
 rtl/mac_array_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mac_array_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_sequencer_pkg
// Brief    : Opcodes, kernel limits and sequencer state encoding shared by the
//            MAC-array sequencer and the instruction decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mac_array_sequencer_pkg;

  // Instruction opcodes understood by the MAC-array sequencer
  localparam logic [31:0] OP_COMPUTE    = 32'd87;
  localparam logic [31:0] OP_LOADIFMAPS = 32'd88;

  // Largest supported kernel dimension (rows of weights per COMPUTE)
  localparam logic [4:0]  MAX_K         = 5'd5;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WREAD   = 3'd1,
    S_WDRAIN  = 3'd2,
    S_WCOMMIT = 3'd3,
    S_COMPUTE = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

  // A kernel dimension is usable when it lies in 1..MAX_K
  function automatic logic k_is_legal(input logic [4:0] k);
    return (k != 5'd0) && (k <= MAX_K);
  endfunction

endpackage : mac_array_sequencer_pkg
`default_nettype wire

// File: rtl/mac_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_sequencer
// Brief    : Sequences a MAC array: reads K weight rows from BRAM, preloads
//            and commits them, then streams ifmap beats from a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mac_array_sequencer
  import mac_array_sequencer_pkg::*;
#(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int IFMAP_CNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   inst,
  input  logic                          inst_valid,
  output logic                          inst_ready,
  input  logic [4:0]                    kernel_size,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base,
  input  logic [IFMAP_CNT_WIDTH-1:0]    ifmap_len,
  input  logic                          soft_clear,
  input  logic                          ifmaps_fifo_empty,
  output logic                          bram_en,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  output logic                          load_weight_preload,
  output logic                          load_MAC_weight,
  output logic                          load_ifmaps,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  seq_state_t                    r_state;
  seq_state_t                    w_next;

  logic [4:0]                    r_k;
  logic [2:0]                    r_row;
  logic [IFMAP_CNT_WIDTH-1:0]    r_len;
  logic [IFMAP_CNT_WIDTH-1:0]    r_cnt;
  logic [BRAM_ADDRESS_WIDTH-1:0] r_bram_addr;
  logic                          r_preload;
  logic                          r_error;

  logic                          w_accept;
  logic                          w_start_weights;
  logic                          w_start_ifmaps;
  logic                          w_reject;
  logic                          w_last_row;
  logic                          w_beats_left;
  logic [IFMAP_CNT_WIDTH-1:0]    w_cnt_inc;
  logic                          w_load_ifmaps;

  // Soft clear wins over a same-cycle handshake, so it also blocks accept.
  assign w_accept        = inst_valid & (r_state == S_IDLE) & ~soft_clear;
  assign w_start_weights = w_accept & (inst == OP_COMPUTE) & k_is_legal(kernel_size);
  assign w_start_ifmaps  = w_accept & (inst == OP_LOADIFMAPS);
  assign w_reject        = w_accept & ~w_start_weights & ~w_start_ifmaps;
  assign w_last_row      = ({2'b00, r_row} == (r_k - 5'd1));
  assign w_beats_left    = (r_cnt != r_len);
  assign w_cnt_inc       = r_cnt + IFMAP_CNT_WIDTH'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the ifmap-load strobe
  always_comb begin
    w_next        = r_state;
    w_load_ifmaps = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_weights) begin
          w_next = S_WREAD;
        end else if (w_start_ifmaps) begin
          // An empty ifmap stream needs no COMPUTE cycle at all.
          w_next = (ifmap_len == '0) ? S_DONE : S_COMPUTE;
        end
      end
      S_WREAD: begin
        if (w_last_row) begin
          w_next = S_WDRAIN;
        end
      end
      S_WDRAIN: begin
        w_next = S_WCOMMIT;
      end
      S_WCOMMIT: begin
        w_next = (r_len == '0) ? S_DONE : S_COMPUTE;
      end
      S_COMPUTE: begin
        // The guard on beats left keeps the strobe off once the count is met.
        w_load_ifmaps = w_beats_left & ~ifmaps_fifo_empty;
        if (!w_beats_left || (w_load_ifmaps && (w_cnt_inc == r_len))) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (soft_clear) begin
      w_next = S_IDLE;
    end
  end

  // Instruction operand capture, row/beat counters, BRAM address, pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_row       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_bram_addr <= '0;
      r_preload   <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error <= w_reject;
      // Preload mirrors the BRAM enable one cycle late to match read latency.
      r_preload <= soft_clear ? 1'b0 : (r_state == S_WREAD);

      if (w_accept) begin
        r_k   <= kernel_size;
        r_len <= ifmap_len;
      end

      if (soft_clear || w_accept) begin
        r_row <= '0;
      end else if (r_state == S_WREAD) begin
        r_row <= r_row + 3'd1;
      end

      if (soft_clear || w_accept) begin
        r_cnt <= '0;
      end else if (w_load_ifmaps) begin
        r_cnt <= w_cnt_inc;
      end

      // Address wraps naturally at the BRAM size; it holds after the last row.
      if (w_start_weights) begin
        r_bram_addr <= weight_base;
      end else if ((r_state == S_WREAD) && !w_last_row) begin
        r_bram_addr <= r_bram_addr + BRAM_ADDRESS_WIDTH'(1);
      end
    end
  end

  assign inst_ready          = (r_state == S_IDLE);
  assign busy                = (r_state != S_IDLE);
  assign done                = (r_state == S_DONE);
  assign bram_en             = (r_state == S_WREAD);
  assign bram_addr           = r_bram_addr;
  assign load_weight_preload = r_preload;
  assign load_MAC_weight     = (r_state == S_WCOMMIT);
  assign load_ifmaps         = w_load_ifmaps;
  assign error               = r_error;

endmodule : mac_array_sequencer
`default_nettype wire
